// File: rtl/mem_pkg.sv
// Shared widths, FSM state encoding and address helper for the memory burst controller.
package mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;
  // Word counter holds up to 256 remaining words.
  localparam int CNT_W  = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    WFLUSH = 2'd3
  } state_t;

  // Burst addresses wrap modulo 256.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/mem_rd_fifo.sv
// Show-ahead read-return FIFO: the head entry (data + last flag) is visible
// whenever the FIFO is non-empty. Data storage is not reset; pointers and
// count are.
module mem_rd_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic              empty_o,
  output logic [OCC_W-1:0]  count_o
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic              last_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [OCC_W-1:0]  count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write on push; contents are don't-care until pushed.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      data_q[wr_ptr_q] <= push_data_i;
      last_q[wr_ptr_q] <= push_last_i;
    end
  end

  // Pointer and occupancy bookkeeping; the caller never pushes when full or pops when empty.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + OCC_W'(push_i) - OCC_W'(pop_i);
    end
  end

  assign empty_o   = (count_q == '0);
  assign rd_data_o = data_q[rd_ptr_q];
  assign rd_last_o = last_q[rd_ptr_q] & ~empty_o;
  assign count_o   = count_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst initiator for the single-port 256x16 memory. One read or write burst
// at a time; reads are flow-controlled by a small return FIFO so that
// RD_READY never reaches the memory-side registers combinationally.
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [LEN_W-1:0]  CMD_LEN,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_LAST,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              DONE,
  output logic              MEM_EN,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA_IN,
  input  logic [DATA_W-1:0] MEM_DATA_OUT
);

  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int OCCS_W = OCC_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;           // next burst address
  logic [CNT_W-1:0]  cnt_q, cnt_d;             // words left to issue (read) / accept (write)
  logic              wr_ready_q, wr_ready_d;
  logic              done_q, done_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_last_q, mem_last_d;   // read on the bus is the burst's final word
  logic              pend_q, pend_d;           // read data arrives on MEM_DATA_OUT this cycle
  logic              pend_last_q, pend_last_d;

  logic              fifo_empty;
  logic              fifo_last;
  logic [OCC_W-1:0]  fifo_cnt;
  logic              rd_pop;
  logic              rd_inflight;
  logic [OCCS_W-1:0] occ;
  logic              can_issue;

  assign rd_pop      = ~fifo_empty & RD_READY;
  assign rd_inflight = mem_en_q & ~mem_write_q;
  // Everything already committed to land in the FIFO, not counting this cycle's pop.
  assign occ         = OCCS_W'(fifo_cnt) + OCCS_W'(rd_inflight) + OCCS_W'(pend_q);
  assign can_issue   = (cnt_q != '0) && (occ < OCCS_W'(DEPTH));

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wr_ready_d  = 1'b0;
    done_d      = 1'b0;
    mem_en_d    = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_last_d  = 1'b0;
    pend_d      = rd_inflight;
    pend_last_d = mem_last_q;
    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          if (CMD_WRITE) begin
            state_d    = WRITE;
            addr_d     = CMD_ADDR;
            cnt_d      = CNT_W'(CMD_LEN) + 1'b1;
            wr_ready_d = 1'b1;
          end else begin
            // First read goes out with the accept edge; the FIFO is empty here.
            state_d    = READ;
            mem_en_d   = 1'b1;
            mem_addr_d = CMD_ADDR;
            mem_last_d = (CMD_LEN == '0);
            addr_d     = addr_inc(CMD_ADDR);
            cnt_d      = CNT_W'(CMD_LEN);
          end
        end
      end
      READ: begin
        if (can_issue) begin
          mem_en_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_last_d = (cnt_q == CNT_W'(1));
          addr_d     = addr_inc(addr_q);
          cnt_d      = cnt_q - 1'b1;
        end
        if (rd_pop && fifo_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      WRITE: begin
        wr_ready_d = wr_ready_q;
        if (WR_VALID && wr_ready_q) begin
          mem_en_d    = 1'b1;
          mem_write_d = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = WR_DATA;
          addr_d      = addr_inc(addr_q);
          cnt_d       = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            wr_ready_d = 1'b0;
            state_d    = WFLUSH;
          end
        end
      end
      WFLUSH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst and in-flight read.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      wr_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_last_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wr_ready_q  <= wr_ready_d;
      done_q      <= done_d;
      mem_en_q    <= mem_en_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_last_q  <= mem_last_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  mem_rd_fifo #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_rd_fifo (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .push_i      (pend_q),
    .push_data_i (MEM_DATA_OUT),
    .push_last_i (pend_last_q),
    .pop_i       (rd_pop),
    .rd_data_o   (RD_DATA),
    .rd_last_o   (fifo_last),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  assign CMD_READY   = (state_q == IDLE);
  assign RD_VALID    = ~fifo_empty;
  assign RD_LAST     = fifo_last;
  assign WR_READY    = wr_ready_q;
  assign DONE        = done_q;
  assign MEM_EN      = mem_en_q;
  assign MEM_WRITE   = mem_write_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_DATA_IN = mem_wdata_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a behavioural 256x16 memory.
module tb_mem_burst_ctrl;
  import mem_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
  logic [7:0]  CMD_ADDR = '0, CMD_LEN = '0;
  logic        RD_VALID, RD_READY = 1'b1, RD_LAST;
  logic [15:0] RD_DATA;
  logic        WR_VALID = 1'b0, WR_READY;
  logic [15:0] WR_DATA = '0;
  logic        DONE, MEM_EN, MEM_WRITE;
  logic [7:0]  MEM_ADDR;
  logic [15:0] MEM_DATA_IN, mem_dout;

  always #5 CLK = ~CLK;

  mem_burst_ctrl #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
    .DONE(DONE), .MEM_EN(MEM_EN), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA_IN(MEM_DATA_IN), .MEM_DATA_OUT(mem_dout)
  );

  // Synchronous memory: read data appears the cycle after the read and holds.
  logic [15:0] mem [256];
  always @(posedge CLK) begin
    if (MEM_EN) begin
      if (MEM_WRITE) mem[MEM_ADDR] <= MEM_DATA_IN;
      else           mem_dout      <= mem[MEM_ADDR];
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct { int cyc; logic [7:0] addr; logic [15:0] data; logic wr; } acc_t;
  typedef struct { int cyc; logic [15:0] data; logic last; } beat_t;
  acc_t  acc_q[$];
  beat_t beat_q[$];
  int    first_rv = -1;
  int    wr_cnt = 0;
  int    issued = 0;
  int    popped = 0;
  logic  mon_en = 1'b0;
  logic  prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic  prev_last;

  // Bus monitor, sampled on the falling edge.
  always @(negedge CLK) begin : mon
    acc_t  a;
    beat_t b;
    if (mon_en) begin
      if (MEM_EN) begin
        a.cyc = cyc; a.addr = MEM_ADDR; a.data = MEM_DATA_IN; a.wr = MEM_WRITE;
        acc_q.push_back(a);
      end else begin
        check("mem_write_without_en", MEM_WRITE, 1'b0);
      end
      if (MEM_EN && !MEM_WRITE) begin
        issued++;
        check("occupancy_le_depth", (issued - popped) <= DEPTH, 1'b1);
      end
      if (prev_stall) begin
        check("stall_valid_hold", RD_VALID, 1'b1);
        check("stall_data_hold", RD_DATA, prev_data);
        check("stall_last_hold", RD_LAST, prev_last);
      end
      if (RD_VALID && RD_READY) begin
        b.cyc = cyc; b.data = RD_DATA; b.last = RD_LAST;
        beat_q.push_back(b);
        popped++;
      end
      if (RD_VALID && first_rv < 0) first_rv = cyc;
      if (WR_VALID && WR_READY) wr_cnt++;
      prev_stall = RD_VALID && !RD_READY;
      prev_data  = RD_DATA;
      prev_last  = RD_LAST;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  len;
    logic [15:0] base;
    int          mode;          // 0: streams always ready/valid, 1: random
    int          exp_done;      // cycle of DONE after accept, -1 = not checked
    logic [7:0]  exp_last_addr;
  } vec_t;

  logic [15:0] sb [256];

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_en"},    MEM_EN, 1'b0);
    check({tag, "_mem_write"}, MEM_WRITE, 1'b0);
    check({tag, "_mem_addr"},  MEM_ADDR, 8'h00);
    check({tag, "_mem_din"},   MEM_DATA_IN, 16'h0000);
    check({tag, "_rd_valid"},  RD_VALID, 1'b0);
    check({tag, "_rd_last"},   RD_LAST, 1'b0);
    check({tag, "_wr_ready"},  WR_READY, 1'b0);
    check({tag, "_done"},      DONE, 1'b0);
    check({tag, "_cmd_ready"}, CMD_READY, 1'b1);
  endtask

  // Runs one burst starting at posedge+1; returns at posedge+1 of the DONE cycle.
  task automatic run_burst(input vec_t v, input int idx);
    int   t0, done_rel, guard, busy_rdy, n;
    logic seen, rdy;
    logic [7:0] ea;
    acc_q.delete(); beat_q.delete();
    first_rv = -1; wr_cnt = 0; issued = 0; popped = 0;
    CMD_VALID = 1'b1; CMD_WRITE = v.wr; CMD_ADDR = v.addr; CMD_LEN = v.len;
    WR_DATA  = v.base;
    WR_VALID = v.wr && (v.mode == 0 || $urandom_range(0, 1) == 1);
    RD_READY = (v.mode == 0) || ($urandom_range(0, 1) == 1);
    @(negedge CLK) rdy = CMD_READY;
    @(posedge CLK); #1;
    check($sformatf("v%0d_cmd_accept", idx), rdy, 1'b1);
    t0 = cyc - 1;
    CMD_VALID = 1'b0;
    seen = 1'b0; busy_rdy = 0; guard = 0; done_rel = -1;
    while (!seen && guard < 3000) begin
      WR_DATA  = v.base + 16'(wr_cnt);
      WR_VALID = v.wr && (wr_cnt <= int'(v.len)) && (v.mode == 0 || $urandom_range(0, 1) == 1);
      RD_READY = (v.mode == 0) || ($urandom_range(0, 1) == 1);
      @(posedge CLK); #1;
      guard++;
      if (DONE) begin
        seen = 1'b1;
        done_rel = cyc - t0;
        check($sformatf("v%0d_cmd_ready_with_done", idx), CMD_READY, 1'b1);
      end else if (CMD_READY) begin
        busy_rdy++;
      end
    end
    WR_VALID = 1'b0;
    RD_READY = 1'b1;
    check($sformatf("v%0d_done_seen", idx), seen, 1'b1);
    check($sformatf("v%0d_cmd_ready_busy_cycles", idx), busy_rdy, 0);
    if (v.exp_done >= 0)
      check($sformatf("v%0d_done_cycle", idx), done_rel, v.exp_done);
    check($sformatf("v%0d_access_count", idx), acc_q.size(), int'(v.len) + 1);
    n = (acc_q.size() < int'(v.len) + 1) ? acc_q.size() : int'(v.len) + 1;
    for (int i = 0; i < n; i++) begin
      ea = v.addr + 8'(i);
      check($sformatf("v%0d_acc%0d_addr", idx, i), acc_q[i].addr, ea);
      check($sformatf("v%0d_acc%0d_wr", idx, i), acc_q[i].wr, v.wr);
      if (v.wr)
        check($sformatf("v%0d_acc%0d_data", idx, i), acc_q[i].data, v.base + 16'(i));
      if (v.mode == 0)
        check($sformatf("v%0d_acc%0d_cycle", idx, i), acc_q[i].cyc - t0, (v.wr ? 2 : 1) + i);
    end
    if (acc_q.size() > 0)
      check($sformatf("v%0d_last_addr", idx), acc_q[acc_q.size()-1].addr, v.exp_last_addr);
    if (!v.wr) begin
      check($sformatf("v%0d_beat_count", idx), beat_q.size(), int'(v.len) + 1);
      if (v.mode == 0)
        check($sformatf("v%0d_first_rd_valid", idx), first_rv - t0, 3);
      n = (beat_q.size() < int'(v.len) + 1) ? beat_q.size() : int'(v.len) + 1;
      for (int i = 0; i < n; i++) begin
        ea = v.addr + 8'(i);
        check($sformatf("v%0d_beat%0d_data", idx, i), beat_q[i].data, sb[ea]);
        check($sformatf("v%0d_beat%0d_last", idx, i), beat_q[i].last, (i == int'(v.len)));
        if (v.mode == 0)
          check($sformatf("v%0d_beat%0d_cycle", idx, i), beat_q[i].cyc - t0, 3 + i);
      end
    end else begin
      for (int i = 0; i <= int'(v.len); i++) begin
        ea = v.addr + 8'(i);
        sb[ea] = v.base + 16'(i);
      end
    end
  endtask

  initial begin
    vec_t vecs[9];
    vec_t rv;
    int   guard, nb, na;

    vecs[0] = '{1'b1, 8'h10, 8'd3,   16'hA000, 0, 6,   8'h13};
    vecs[1] = '{1'b0, 8'h10, 8'd3,   16'h0000, 0, 7,   8'h13};
    vecs[2] = '{1'b1, 8'd250, 8'd8,  16'hB000, 0, 11,  8'h02};
    vecs[3] = '{1'b0, 8'd250, 8'd8,  16'h0000, 0, 12,  8'h02};
    vecs[4] = '{1'b1, 8'h00, 8'd255, 16'hC000, 0, 258, 8'hFF};
    vecs[5] = '{1'b0, 8'h00, 8'd255, 16'h0000, 0, 259, 8'hFF};
    vecs[6] = '{1'b0, 8'h20, 8'd15,  16'h0000, 1, -1,  8'h2F};
    vecs[7] = '{1'b1, 8'h40, 8'd5,   16'hD000, 1, -1,  8'h45};
    vecs[8] = '{1'b0, 8'h40, 8'd5,   16'h0000, 0, 9,   8'h45};

    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state("init");
    RST = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) run_burst(vecs[i], i);

    // Reset in the middle of a 10-word read, after its 5th beat.
    acc_q.delete(); beat_q.delete();
    issued = 0; popped = 0; first_rv = -1;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 8'h00; CMD_LEN = 8'd9; RD_READY = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    guard = 0;
    while (beat_q.size() < 5 && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    check("midrst_five_beats", beat_q.size(), 5);
    for (int i = 0; i < beat_q.size() && i < 5; i++)
      check($sformatf("midrst_beat%0d_data", i), beat_q[i].data, 16'hC000 + 16'(i));
    RST = 1'b0;
    mon_en = 1'b0;
    @(posedge CLK); #1;
    check_reset_state("midrst");
    RST = 1'b1;
    prev_stall = 1'b0;
    mon_en = 1'b1;
    nb = beat_q.size();
    na = acc_q.size();
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      check($sformatf("postrst%0d_mem_en", i), MEM_EN, 1'b0);
      check($sformatf("postrst%0d_rd_valid", i), RD_VALID, 1'b0);
      check($sformatf("postrst%0d_done", i), DONE, 1'b0);
    end
    check("postrst_no_new_beats", beat_q.size(), nb);
    check("postrst_no_new_access", acc_q.size(), na);

    rv = '{1'b0, 8'h80, 8'd3, 16'h0000, 0, 7, 8'h83};
    run_burst(rv, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
